hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the five-stage RV64 core.
- Watches register indices and control bits leaving decode, execute, memory and writeback.
- Drives stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the execute-stage forwarding selects.
- Sequences three cases: load-use bubbles, taken branch/jump flushes, and data-memory wait freezes.

Parameters:
- LOAD_USE_STALLS, 1, number of bubble cycles inserted on a load-use hazard (1..3).
- RESULT_SRC_LOAD, 2'b01, result_src encoding that marks a load.
- PERF_W, 32, width of the performance counters (used only with HAZARD_PERF_EN).

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rs1_id, rs2_id  in  5  source registers of the instruction in decode.
- rs1_ex, rs2_ex  in  5  source registers in execute.
- rd_ex  in  5  destination register in execute.
- result_src_ex  in  2  result select in execute.
- reg_write_ex  in  1  execute instruction writes the register file.
- rd_mem, rd_wb  in  5  destination registers in memory / writeback.
- reg_write_mem, reg_write_wb  in  1  register write enables in memory / writeback.
- pc_src_ex  in  1  branch taken or jump resolved in execute.
- dmem_req  in  1  memory stage issuing a data access.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_fetch, stall_decode, stall_execute, stall_memory  out  1  hold the PC / corresponding pipeline register.
- flush_decode, flush_execute  out  1  load a bubble into IF/ID / ID/EX.
- forward_a_ex, forward_b_ex  out  2  operand select: 00 register file, 10 memory-stage result, 01 writeback result.
- perf_stall_cycles, perf_flushes  out  PERF_W  counters (only with HAZARD_PERF_EN).

Behaviour:
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN, stall counter is 0.
- While reset_n=0: flush_decode=flush_execute=1, all stalls 0, forwards 00.
- Definitions:
  - lu = (result_src_ex==RESULT_SRC_LOAD) & reg_write_ex & rd_ex!=0 & (rd_ex==rs1_id | rd_ex==rs2_id)
  - mw = dmem_req & !dmem_ready
- Outputs are Mealy: they are combinational from state plus inputs in the same cycle. Default for every stall/flush output is 0.
- Priority in RUN: mw > pc_src_ex > lu.
  - mw: all four stalls=1, no flush; next state MEM_WAIT.
  - pc_src_ex: flush_decode=flush_execute=1; stay in RUN. A concurrent lu is discarded because the decode instruction is squashed.
  - lu: stall_fetch=stall_decode=1, flush_execute=1. If LOAD_USE_STALLS>1, load counter with LOAD_USE_STALLS-1 and go to LU_STALL; otherwise stay in RUN.
- LU_STALL:
  - Outputs stall_fetch=stall_decode=1, flush_execute=1; counter decrements each cycle.
  - Counter reaching 0 returns to RUN.
  - mw arriving in this state takes priority: all stalls=1, counter frozen, go to MEM_WAIT, then return to LU_STALL on exit (saved return-state bit).
- MEM_WAIT:
  - All stalls=1 while !dmem_ready.
  - In the cycle dmem_ready=1: behave exactly as the return state (RUN evaluation, or LU_STALL outputs) and transition to that state.
  - pc_src_ex held during the freeze is acted on in that release cycle.
- Forwarding is combinational and independent of the FSM:
  - forward_a = 10 if reg_write_mem & rd_mem!=0 & rd_mem==rs1_ex; else 01 if reg_write_wb & rd_wb!=0 & rd_wb==rs1_ex; else 00.
  - Memory stage has priority over writeback. forward_b uses rs2_ex the same way.
- Register x0 never triggers a hazard or a forward.

Optional Feature:
- HAZARD_PERF_EN defined: perf_stall_cycles increments in every cycle with stall_decode=1, and perf_flushes increments in every cycle with flush_decode=1. Both clear on reset and saturate at all-ones.
- HAZARD_PERF_EN not defined: the counter ports and logic are absent.

Decomposition:
- Shared package core_pkg holds the FSM state enum, the result_src encodings (RESULT_SRC_LOAD) and the forward-select constants FWD_RF, FWD_MEM, FWD_WB.
- One natural sub-module: fwd_unit, the purely combinational forwarding select, instantiated once per operand.

Test Plan:
- Load-use: rd_ex=5, result_src_ex=01, reg_write_ex=1, rs1_id=5 -> that cycle stall_fetch=stall_decode=flush_execute=1; next cycle all 0 (LOAD_USE_STALLS=1).
- Branch beats load-use: pc_src_ex=1 with the same lu inputs -> flush_decode=flush_execute=1, stall_decode=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all stalls=1 for exactly 3 cycles, 0 on the ready cycle.
- Forward priority: rs1_ex=7, rd_mem=7, rd_wb=7, both write enables=1 -> forward_a_ex=10; with rd_mem=0 -> 01; with rs1_ex=0 -> 00.
- Reset mid-stall: LOAD_USE_STALLS=3, reset_n=0 in the 2nd stall cycle -> next cycle state RUN, flush_decode=flush_execute=1 while reset is held, stalls 0.
- HAZARD_PERF_EN: 2 lu events plus 1 branch -> perf_stall_cycles=2, perf_flushes=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, result-select encodings and
// execute-stage forwarding selects.
package core_pkg;

   typedef enum logic [1:0] {
      StRun,
      StLuStall,
      StMemWait
   } hz_state_e;

   localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
   localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Execute-stage operand forwarding select for one source register.
// Memory-stage result wins over writeback; x0 is never forwarded.
module fwd_unit
   import core_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_mem,
   input  logic       reg_write_mem,
   input  logic [4:0] rd_wb,
   input  logic       reg_write_wb,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
         sel = FWD_MEM;
      end else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes, data-memory
// wait freezes and operand forwarding. HAZARD_PERF_EN adds stall/flush counters.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int unsigned LOAD_USE_STALLS = 1,
   parameter int unsigned PERF_W          = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [4:0]        rs1_id,
   input  logic [4:0]        rs2_id,
   input  logic [4:0]        rs1_ex,
   input  logic [4:0]        rs2_ex,
   input  logic [4:0]        rd_ex,
   input  logic [1:0]        result_src_ex,
   input  logic              reg_write_ex,
   input  logic [4:0]        rd_mem,
   input  logic [4:0]        rd_wb,
   input  logic              reg_write_mem,
   input  logic              reg_write_wb,
   input  logic              pc_src_ex,
   input  logic              dmem_req,
   input  logic              dmem_ready,
   output logic              stall_fetch,
   output logic              stall_decode,
   output logic              stall_execute,
   output logic              stall_memory,
   output logic              flush_decode,
   output logic              flush_execute,
   output logic [1:0]        forward_a_ex,
   output logic [1:0]        forward_b_ex
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cycles,
   output logic [PERF_W-1:0] perf_flushes
`endif
);

   localparam int unsigned       CNT_W      = 2;
   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(LOAD_USE_STALLS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ret_lu_q, ret_lu_d;
   logic             lu, mw;
   logic             act_run, act_lu;
   logic [1:0]       fwd_a, fwd_b;

   assign lu = (result_src_ex == RESULT_SRC_LOAD) && reg_write_ex && (rd_ex != 5'd0) &&
               ((rd_ex == rs1_id) || (rd_ex == rs2_id));
   assign mw = dmem_req && !dmem_ready;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ret_lu_d      = ret_lu_q;
      act_run       = 1'b0;
      act_lu        = 1'b0;
      stall_fetch   = 1'b0;
      stall_decode  = 1'b0;
      stall_execute = 1'b0;
      stall_memory  = 1'b0;
      flush_decode  = 1'b0;
      flush_execute = 1'b0;

      unique case (state_q)
         StRun:     act_run = 1'b1;
         StLuStall: act_lu  = 1'b1;
         StMemWait: begin
            if (!dmem_ready) begin
               stall_fetch   = 1'b1;
               stall_decode  = 1'b1;
               stall_execute = 1'b1;
               stall_memory  = 1'b1;
            end else if (ret_lu_q) begin
               act_lu = 1'b1;
            end else begin
               act_run = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase

      if (act_run) begin
         state_d = StRun;
         if (mw) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            stall_memory  = 1'b1;
            ret_lu_d      = 1'b0;
            state_d       = StMemWait;
         end else if (pc_src_ex) begin
            // The decode instruction is squashed, so any load-use on it is moot.
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
         end else if (lu) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
               cnt_d   = CNT_RELOAD;
               state_d = StLuStall;
            end
         end
      end

      if (act_lu) begin
         if (mw) begin
            // Counter frozen; the bubble sequence resumes after the freeze.
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            stall_memory  = 1'b1;
            ret_lu_d      = 1'b1;
            state_d       = StMemWait;
         end else begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
            cnt_d         = cnt_q - CNT_ONE;
            state_d       = (cnt_q == CNT_ONE) ? StRun : StLuStall;
         end
      end

      if (!reset_n) begin
         stall_fetch   = 1'b0;
         stall_decode  = 1'b0;
         stall_execute = 1'b0;
         stall_memory  = 1'b0;
         flush_decode  = 1'b1;
         flush_execute = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= StRun;
         cnt_q    <= '0;
         ret_lu_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ret_lu_q <= ret_lu_d;
      end
   end

   fwd_unit u_fwd_a (
      .rs            (rs1_ex),
      .rd_mem        (rd_mem),
      .reg_write_mem (reg_write_mem),
      .rd_wb         (rd_wb),
      .reg_write_wb  (reg_write_wb),
      .sel           (fwd_a)
   );

   fwd_unit u_fwd_b (
      .rs            (rs2_ex),
      .rd_mem        (rd_mem),
      .reg_write_mem (reg_write_mem),
      .rd_wb         (rd_wb),
      .reg_write_wb  (reg_write_wb),
      .sel           (fwd_b)
   );

   assign forward_a_ex = reset_n ? fwd_a : FWD_RF;
   assign forward_b_ex = reset_n ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         perf_stall_cycles <= '0;
         perf_flushes      <= '0;
      end else begin
         if (stall_decode && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 1'b1;
         end
         if (flush_decode && (perf_flushes != '1)) begin
            perf_flushes <= perf_flushes + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load-use bubbles) share stimulus;
// directed scenarios plus a randomized run against a behavioural model.
module tb_hazard_ctrl;

   localparam logic [5:0] EXP_NONE = 6'b000000;
   localparam logic [5:0] EXP_ALL  = 6'b111100;  // {sf,sd,se,sm,fd,fe}
   localparam logic [5:0] EXP_LU   = 6'b110001;
   localparam logic [5:0] EXP_BR   = 6'b000011;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
   logic [1:0] result_src_ex;
   logic       reg_write_ex, reg_write_mem, reg_write_wb;
   logic       pc_src_ex, dmem_req, dmem_ready;

   logic [1:0] sf, sd, se, sm, fd, fe;
   logic [1:0] fa [2];
   logic [1:0] fb [2];
`ifdef HAZARD_PERF_EN
   logic [31:0] ps [2];
   logic [31:0] pf [2];
`endif

   int passed = 0;
   int total  = 0;

   // Model: pending bubbles and whether a memory freeze is in progress.
   int m_rem  [2];
   bit m_wait [2];
   int lus    [2] = '{1, 3};

   always #5 clock = ~clock;

   hazard_ctrl #(.LOAD_USE_STALLS(1)) dut1 (
      .clock(clock), .reset_n(reset_n),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
      .rd_ex(rd_ex), .result_src_ex(result_src_ex), .reg_write_ex(reg_write_ex),
      .rd_mem(rd_mem), .rd_wb(rd_wb), .reg_write_mem(reg_write_mem),
      .reg_write_wb(reg_write_wb), .pc_src_ex(pc_src_ex), .dmem_req(dmem_req),
      .dmem_ready(dmem_ready),
      .stall_fetch(sf[0]), .stall_decode(sd[0]), .stall_execute(se[0]),
      .stall_memory(sm[0]), .flush_decode(fd[0]), .flush_execute(fe[0]),
      .forward_a_ex(fa[0]), .forward_b_ex(fb[0])
`ifdef HAZARD_PERF_EN
      , .perf_stall_cycles(ps[0]), .perf_flushes(pf[0])
`endif
   );

   hazard_ctrl #(.LOAD_USE_STALLS(3)) dut3 (
      .clock(clock), .reset_n(reset_n),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
      .rd_ex(rd_ex), .result_src_ex(result_src_ex), .reg_write_ex(reg_write_ex),
      .rd_mem(rd_mem), .rd_wb(rd_wb), .reg_write_mem(reg_write_mem),
      .reg_write_wb(reg_write_wb), .pc_src_ex(pc_src_ex), .dmem_req(dmem_req),
      .dmem_ready(dmem_ready),
      .stall_fetch(sf[1]), .stall_decode(sd[1]), .stall_execute(se[1]),
      .stall_memory(sm[1]), .flush_decode(fd[1]), .flush_execute(fe[1]),
      .forward_a_ex(fa[1]), .forward_b_ex(fb[1])
`ifdef HAZARD_PERF_EN
      , .perf_stall_cycles(ps[1]), .perf_flushes(pf[1])
`endif
   );

   function automatic logic [5:0] obs(int i);
      return {sf[i], sd[i], se[i], sm[i], fd[i], fe[i]};
   endfunction

   function automatic bit model_lu();
      return result_src_ex == 2'b01 && reg_write_ex && rd_ex != 0 &&
             (rd_ex == rs1_id || rd_ex == rs2_id);
   endfunction

   function automatic logic [5:0] model_out(int i);
      if (!reset_n) return EXP_BR;
      if (m_wait[i] && !dmem_ready) return EXP_ALL;
      if (dmem_req && !dmem_ready) return EXP_ALL;
      if (m_rem[i] > 0) return EXP_LU;
      if (pc_src_ex) return EXP_BR;
      if (model_lu()) return EXP_LU;
      return EXP_NONE;
   endfunction

   function automatic logic [1:0] fwd_exp(logic [4:0] rs);
      if (!reset_n) return 2'b00;
      if (reg_write_mem && rd_mem != 0 && rd_mem == rs) return 2'b10;
      if (reg_write_wb && rd_wb != 0 && rd_wb == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            m_rem[i]  = 0;
            m_wait[i] = 0;
         end else if (m_wait[i] && !dmem_ready) begin
            m_wait[i] = 1;
         end else if (dmem_req && !dmem_ready) begin
            m_wait[i] = 1;
         end else begin
            m_wait[i] = 0;
            if (m_rem[i] > 0) m_rem[i]--;
            else if (pc_src_ex) m_rem[i] = m_rem[i];
            else if (model_lu()) m_rem[i] = lus[i] - 1;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      reset_n = 1; rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0;
      rd_mem = 0; rd_wb = 0; result_src_ex = 0; reg_write_ex = 0; reg_write_mem = 0;
      reg_write_wb = 0; pc_src_ex = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   task automatic set_lu();
      rd_ex = 5; result_src_ex = 2'b01; reg_write_ex = 1; rs1_id = 5;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 0; set_lu(); dmem_req = 1;
      rs1_ex = 7; rd_mem = 7; reg_write_mem = 1;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== EXP_BR) $display("FAIL reset_out dut%0d got %b want %b", i, obs(i), EXP_BR);
         else passed++;
         total++;
         if (fa[i] !== 2'b00) $display("FAIL reset_fwd dut%0d got %b want 00", i, fa[i]);
         else passed++;
      end
      tick();
      tick();
      clear_inputs();
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== EXP_NONE) $display("FAIL reset_idle dut%0d got %b want %b", i, obs(i), EXP_NONE);
         else passed++;
      end
   endtask

   task automatic test_load_use();
      logic [5:0] exp1 [4] = '{EXP_LU, EXP_NONE, EXP_NONE, EXP_NONE};
      logic [5:0] exp3 [4] = '{EXP_LU, EXP_LU, EXP_LU, EXP_NONE};
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         if (c == 0) set_lu();
         #1;
         total++;
         if (obs(0) !== exp1[c]) $display("FAIL lu1_c%0d got %b want %b", c, obs(0), exp1[c]);
         else passed++;
         total++;
         if (obs(1) !== exp3[c]) $display("FAIL lu3_c%0d got %b want %b", c, obs(1), exp3[c]);
         else passed++;
         tick();
      end
      // x0 destination and a non-load result never stall.
      clear_inputs(); set_lu(); rd_ex = 0; rs1_id = 0;
      #1;
      total++;
      if (obs(0) !== EXP_NONE) $display("FAIL lu_x0 got %b want %b", obs(0), EXP_NONE);
      else passed++;
      tick();
      clear_inputs(); set_lu(); rs1_id = 0; rs2_id = 5; result_src_ex = 2'b00;
      #1;
      total++;
      if (obs(1) !== EXP_NONE) $display("FAIL lu_alu got %b want %b", obs(1), EXP_NONE);
      else passed++;
      tick();
   endtask

   task automatic test_branch();
      clear_inputs(); set_lu(); pc_src_ex = 1;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== EXP_BR) $display("FAIL branch dut%0d got %b want %b", i, obs(i), EXP_BR);
         else passed++;
      end
      tick();
      clear_inputs();
      #1;
      total++;
      if (obs(1) !== EXP_NONE) $display("FAIL branch_after got %b want %b", obs(1), EXP_NONE);
      else passed++;
      tick();
   endtask

   task automatic test_mem_wait();
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 4; c++) begin
            clear_inputs();
            dmem_req = 1; dmem_ready = (c == 3); pc_src_ex = (s == 1);
            #1;
            for (int i = 0; i < 2; i++) begin
               total++;
               if (c < 3 && obs(i) !== EXP_ALL)
                  $display("FAIL memwait_s%0d_c%0d dut%0d got %b want %b", s, c, i, obs(i), EXP_ALL);
               else if (c == 3 && obs(i) !== (s == 1 ? EXP_BR : EXP_NONE))
                  $display("FAIL memrel_s%0d dut%0d got %b want %b", s, i, obs(i),
                           (s == 1 ? EXP_BR : EXP_NONE));
               else passed++;
            end
            tick();
         end
      end
   endtask

   task automatic test_mw_in_lu();
      logic [5:0] exp1 [6] = '{EXP_LU, EXP_ALL, EXP_ALL, EXP_NONE, EXP_NONE, EXP_NONE};
      logic [5:0] exp3 [6] = '{EXP_LU, EXP_ALL, EXP_ALL, EXP_LU, EXP_LU, EXP_NONE};
      for (int c = 0; c < 6; c++) begin
         clear_inputs();
         if (c == 0) set_lu();
         if (c >= 1 && c <= 3) dmem_req = 1;
         dmem_ready = (c == 3);
         #1;
         total++;
         if (obs(0) !== exp1[c]) $display("FAIL mwlu1_c%0d got %b want %b", c, obs(0), exp1[c]);
         else passed++;
         total++;
         if (obs(1) !== exp3[c]) $display("FAIL mwlu3_c%0d got %b want %b", c, obs(1), exp3[c]);
         else passed++;
         tick();
      end
   endtask

   task automatic test_forward();
      logic [4:0] rs_v [4] = '{7, 7, 0, 7};
      logic [4:0] rm_v [4] = '{7, 0, 0, 7};
      logic       wm_v [4] = '{1, 1, 1, 0};
      logic [1:0] ex_v [4] = '{2'b10, 2'b01, 2'b00, 2'b01};
      for (int k = 0; k < 4; k++) begin
         clear_inputs();
         rs1_ex = rs_v[k]; rs2_ex = rs_v[k]; rd_mem = rm_v[k]; rd_wb = 7;
         reg_write_mem = wm_v[k]; reg_write_wb = 1;
         #1;
         total++;
         if (fa[0] !== ex_v[k]) $display("FAIL fwd_a_%0d got %b want %b", k, fa[0], ex_v[k]);
         else passed++;
         total++;
         if (fb[1] !== ex_v[k]) $display("FAIL fwd_b_%0d got %b want %b", k, fb[1], ex_v[k]);
         else passed++;
      end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs(); set_lu();
      #1;
      total++;
      if (obs(1) !== EXP_LU) $display("FAIL rms_lu got %b want %b", obs(1), EXP_LU);
      else passed++;
      tick();
      clear_inputs(); reset_n = 0;
      for (int c = 0; c < 2; c++) begin
         #1;
         total++;
         if (obs(1) !== EXP_BR) $display("FAIL rms_held_c%0d got %b want %b", c, obs(1), EXP_BR);
         else passed++;
         tick();
      end
      clear_inputs();
      #1;
      total++;
      if (obs(1) !== EXP_NONE) $display("FAIL rms_run got %b want %b", obs(1), EXP_NONE);
      else passed++;
      tick();
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      clear_inputs(); reset_n = 0;
      tick();
      for (int c = 0; c < 6; c++) begin
         clear_inputs();
         if (c == 0 || c == 2) set_lu();
         if (c == 4) pc_src_ex = 1;
         tick();
      end
      total++;
      if (ps[0] !== 32'd2) $display("FAIL perf_stall got %0d want 2", ps[0]);
      else passed++;
      total++;
      if (pf[0] !== 32'd1) $display("FAIL perf_flush got %0d want 1", pf[0]);
      else passed++;
   endtask
`endif

   task automatic test_random();
      logic [5:0] e;
      for (int n = 0; n < 400; n++) begin
         reset_n       = ($urandom_range(0, 39) != 0);
         rs1_id        = 5'($urandom_range(0, 3));
         rs2_id        = 5'($urandom_range(0, 3));
         rs1_ex        = 5'($urandom_range(0, 3));
         rs2_ex        = 5'($urandom_range(0, 3));
         rd_ex         = 5'($urandom_range(0, 3));
         rd_mem        = 5'($urandom_range(0, 3));
         rd_wb         = 5'($urandom_range(0, 3));
         result_src_ex = 2'($urandom_range(0, 3));
         reg_write_ex  = 1'($urandom_range(0, 1));
         reg_write_mem = 1'($urandom_range(0, 1));
         reg_write_wb  = 1'($urandom_range(0, 1));
         pc_src_ex     = ($urandom_range(0, 5) == 0);
         dmem_req      = ($urandom_range(0, 2) == 0);
         dmem_ready    = 1'($urandom_range(0, 1));
         #1;
         for (int i = 0; i < 2; i++) begin
            e = model_out(i);
            total++;
            if (obs(i) !== e) $display("FAIL rand_out n%0d dut%0d got %b want %b", n, i, obs(i), e);
            else passed++;
            total++;
            if (fa[i] !== fwd_exp(rs1_ex) || fb[i] !== fwd_exp(rs2_ex))
               $display("FAIL rand_fwd n%0d dut%0d got %b/%b want %b/%b", n, i, fa[i], fb[i],
                        fwd_exp(rs1_ex), fwd_exp(rs2_ex));
            else passed++;
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_rem[i]  = 0;
         m_wait[i] = 0;
      end
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_mw_in_lu();
      test_forward();
      test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
